snake_stream: RTL and testbench
===============================

// Module: snake_stream
// PURPOSE
// - Owns the snake body and serializes it, head to tail, one segment per cycle, into the VGA renderer's segment stream.
// - Body is a circular buffer of 2-bit links plus a head coordinate; positions are rebuilt while walking.
// - Applies move/grow requests only between walks, so no walk ever shows a half-moved snake.
// - Detects wall and self collision; raises failure/success for the game controller.
// PARAMETERS
// - MAX_LEN      32  body capacity in segments (power of 2, >= START_LEN+1)
// - GAME_WIDTH   18  playfield columns, legal x = 1..GAME_WIDTH
// - GAME_HEIGHT  13  playfield rows, legal y = 1..GAME_HEIGHT
// - START_X/Y    4/7 head tile after reset
// - START_LEN    3   body length after reset; body extends leftwards from head
// PORTS
// - clk          in  1  single clock
// - rst          in  1  synchronous, active-high reset
// - game_rst     in  1  synchronous game restart; same effect as rst
// - move         in  1  single-cycle move request
// - move_dir     in  2  0=up 1=down 2=left 3=right, sampled with move
// - grow         in  1  sampled with move; 1 = keep tail (length+1)
// - move_done    out 1  one-cycle pulse when a request is resolved (moved or failed)
// - snake_head_x/y out 5/4  committed head tile
// - snake_x/y    out 5/4  streamed segment tile
// - snake_dir    out 2  link from this segment toward its tail-ward neighbour
// - snake_first/last out 1  segment is head / tail
// - snake_valid  out 1  stream qualifier
// - length       out 6  current segment count
// - failure      out 1  sticky; set on wall or self hit
// - success      out 1  sticky; set when length reaches MAX_LEN
// BEHAVIOUR
// - Reset (rst|game_rst): length=START_LEN, head=(START_X,START_Y), all links=2 (left).
//   Reset also clears failure/success/move_done/pending and all stream outputs (0), walk index k=0.
// - Walk: cycle k=0..length-1 drives segment k, registered, valid=1.
//   - first=(k==0), last=(k==length-1).
//   - Segment k+1 = segment k stepped one tile along link k: up y-1, down y+1, left x-1, right x+1.
//   - After the last segment, one gap cycle with valid=0 follows; period = length+1 cycles.
// - Request: move sets pending. A second move while pending overwrites dir/grow and does not queue.
// - Arming: at k=0, if pending, arm the request.
//   - Candidate head = head stepped by move_dir; clear pending.
// - Check: during an armed walk, every streamed segment except the tail is compared with the candidate.
//   - The tail is compared too when grow=1. A match sets hit.
// - Commit, at the gap cycle of the armed walk:
//   - Candidate off playfield, or hit: failure<=1; body unchanged.
//   - Otherwise: head<=candidate; head pointer decrements mod MAX_LEN; new link = opposite(move_dir) ({d[1],~d[0]}).
//   - grow=1 and length<MAX_LEN: length+1. Reaching MAX_LEN sets success.
//   - grow=1 at MAX_LEN: treated as grow=0.
//   - move_done pulses in the gap cycle in all three cases.
//   - Latency from move to move_done: <= 2*(length+1)+1 cycles.
// - Moving into the neck (reverse) is an ordinary self hit.
// - While failure or success: requests are ignored (no move_done) and streaming continues unchanged.
// - rst mid-walk: stream restarts at k=0 on the next cycle; an armed request is discarded.
// CONFIGURATION
// - SNAKE_WRAP_EN defined:
//   - A candidate leaving the field wraps: x 0->GAME_WIDTH, GAME_WIDTH+1->1, same rule for y.
//   - Wall hits never fail; the streamed walk applies the same wrap.
// - SNAKE_WRAP_EN undefined:
//   - A candidate outside 1..GAME_WIDTH / 1..GAME_HEIGHT sets failure at commit.
// TESTING
// - Reset release -> stream (4,7,first),(3,7),(2,7,last), dir=2 on each, then valid=0 for 1 cycle; repeats every 4 cycles.
// - move dir=3, grow=0 -> move_done at a gap; next walk (5,7),(4,7),(3,7); head_x=5, length=3.
// - move dir=3, grow=1 -> walk (5,7),(4,7),(3,7),(2,7); length=4; first segment dir=2.
// - From reset, move dir=2 -> hits neck (3,7): failure=1, move_done pulses, walk unchanged.
//   A later move gives no move_done.
// - Head at (18,7), move dir=3:
//   - without SNAKE_WRAP_EN: failure=1, head stays (18,7);
//   - with SNAKE_WRAP_EN: head=(1,7), failure=0.
// - MAX_LEN=8: five grow moves -> length=8, success=1. Further moves are ignored.
//   game_rst -> length=3, success=0, failure=0.

Source files
------------

// File: rtl/snake_stream_if.sv
// rtl/snake_stream_if.sv - move request handshake and segment stream bundle for snake_stream
interface snake_stream_if;
  logic       move;
  logic [1:0] move_dir;
  logic       grow;
  logic       move_done;
  logic [4:0] snake_x;
  logic [3:0] snake_y;
  logic [1:0] snake_dir;
  logic       snake_first;
  logic       snake_last;
  logic       snake_valid;

  modport master (
    input  move, move_dir, grow,
    output move_done, snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid
  );

  modport slave (
    output move, move_dir, grow,
    input  move_done, snake_x, snake_y, snake_dir, snake_first, snake_last, snake_valid
  );
endinterface

// File: rtl/snake_stream.sv
// rtl/snake_stream.sv - snake body store that streams segments head to tail and applies moves between walks
// Optional playfield wrap-around is enabled by defining SNAKE_WRAP_EN.
module snake_stream #(
  parameter int MAX_LEN     = 32,
  parameter int GAME_WIDTH  = 18,
  parameter int GAME_HEIGHT = 13,
  parameter int START_X     = 4,
  parameter int START_Y     = 7,
  parameter int START_LEN   = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           game_rst,
  snake_stream_if.master bus,
  output logic [4:0]     snake_head_x,
  output logic [3:0]     snake_head_y,
  output logic [5:0]     length,
  output logic           failure,
  output logic           success
);
  localparam int         PW = $clog2(MAX_LEN);
  localparam logic [4:0] GW = 5'(GAME_WIDTH);
  localparam logic [3:0] GH = 4'(GAME_HEIGHT);

  typedef enum logic [1:0] {S_PLAY, S_ARMED, S_FAIL, S_WIN} state_t;
  state_t state, state_nx;

  logic [1:0]    links [MAX_LEN];
  logic [PW-1:0] hp;
  logic [5:0]    k;
  logic [4:0]    wx, nx, cand_x;
  logic [3:0]    wy, ny, cand_y;
  logic          pending, pend_grow, arm_grow, hit;
  logic [1:0]    pend_dir, arm_dir, cur_link;
  logic          clear, in_walk, at_gap, grow_eff, off_field, bad, seg_hit;
  logic          arm, accept, done_c, commit_ok;

  function automatic logic [8:0] step(input logic [4:0] x, input logic [3:0] y, input logic [1:0] d);
    logic [4:0] sx;
    logic [3:0] sy;
    sx = x;
    sy = y;
    case (d)
      2'd0:    sy = y - 4'd1;
      2'd1:    sy = y + 4'd1;
      2'd2:    sx = x - 5'd1;
      default: sx = x + 5'd1;
    endcase
`ifdef SNAKE_WRAP_EN
    if (sx == 5'd0) sx = GW;
    else if (sx == GW + 5'd1) sx = 5'd1;
    if (sy == 4'd0) sy = GH;
    else if (sy == GH + 4'd1) sy = 4'd1;
`endif
    return {sx, sy};
  endfunction

  assign clear    = rst | game_rst;
  assign in_walk  = (k < length);
  assign at_gap   = (k == length);
  assign cur_link = links[hp + k[PW-1:0]];
  assign grow_eff = arm_grow && (length < 6'(MAX_LEN));
  assign {nx, ny}         = step(wx, wy, cur_link);
  assign {cand_x, cand_y} = step(snake_head_x, snake_head_y, arm_dir);

`ifdef SNAKE_WRAP_EN
  assign off_field = 1'b0;
`else
  assign off_field = (cand_x == 5'd0) || (cand_x > GW) || (cand_y == 4'd0) || (cand_y > GH);
`endif
  assign bad = off_field || hit;

  // The tail vacates its tile during a plain move, so it only blocks when growing.
  assign seg_hit = (state == S_ARMED) && in_walk && ((k != length - 6'd1) || grow_eff)
                   && (wx == cand_x) && (wy == cand_y);

  always_ff @(posedge clk) begin
    if (clear) state <= S_PLAY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_PLAY:  if (arm) state_nx = S_ARMED;
      S_ARMED: if (at_gap) begin
        if (bad)                                         state_nx = S_FAIL;
        else if (grow_eff && length == 6'(MAX_LEN - 1)) state_nx = S_WIN;
        else                                             state_nx = S_PLAY;
      end
      default: state_nx = state;
    endcase
  end

  always_comb begin
    arm       = 1'b0;
    accept    = 1'b0;
    done_c    = 1'b0;
    commit_ok = 1'b0;
    failure   = 1'b0;
    success   = 1'b0;
    case (state)
      S_PLAY: begin
        accept = 1'b1;
        arm    = pending && (k == 6'd0);
      end
      S_ARMED: begin
        accept    = 1'b1;
        done_c    = at_gap;
        commit_ok = at_gap && !bad;
      end
      S_FAIL:  failure = 1'b1;
      default: success = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < MAX_LEN; i++) links[i] <= 2'd2;
      hp              <= '0;
      k               <= 6'd0;
      length          <= 6'(START_LEN);
      snake_head_x    <= 5'(START_X);
      snake_head_y    <= 4'(START_Y);
      wx              <= 5'(START_X);
      wy              <= 4'(START_Y);
      pending         <= 1'b0;
      pend_dir        <= 2'd0;
      pend_grow       <= 1'b0;
      arm_dir         <= 2'd0;
      arm_grow        <= 1'b0;
      hit             <= 1'b0;
      bus.move_done   <= 1'b0;
      bus.snake_x     <= 5'd0;
      bus.snake_y     <= 4'd0;
      bus.snake_dir   <= 2'd0;
      bus.snake_first <= 1'b0;
      bus.snake_last  <= 1'b0;
      bus.snake_valid <= 1'b0;
    end else begin
      bus.move_done <= done_c;

      // A fresh request landing on the arming cycle stays pending for the next walk.
      if (bus.move && accept) begin
        pending   <= 1'b1;
        pend_dir  <= bus.move_dir;
        pend_grow <= bus.grow;
      end else if (arm) begin
        pending <= 1'b0;
      end

      if (arm) begin
        arm_dir  <= pend_dir;
        arm_grow <= pend_grow;
        hit      <= 1'b0;
      end else if (seg_hit) begin
        hit <= 1'b1;
      end

      if (in_walk) begin
        bus.snake_x     <= wx;
        bus.snake_y     <= wy;
        bus.snake_dir   <= cur_link;
        bus.snake_first <= (k == 6'd0);
        bus.snake_last  <= (k == length - 6'd1);
        bus.snake_valid <= 1'b1;
        wx              <= nx;
        wy              <= ny;
        k               <= k + 6'd1;
      end else begin
        bus.snake_first <= 1'b0;
        bus.snake_last  <= 1'b0;
        bus.snake_valid <= 1'b0;
        k               <= 6'd0;
        if (commit_ok) begin
          snake_head_x         <= cand_x;
          snake_head_y         <= cand_y;
          hp                   <= hp - PW'(1);
          links[hp - PW'(1)]   <= {arm_dir[1], ~arm_dir[0]};
          wx                   <= cand_x;
          wy                   <= cand_y;
          if (grow_eff) length <= length + 6'd1;
        end else begin
          wx <= snake_head_x;
          wy <= snake_head_y;
        end
      end
    end
  end
endmodule

// File: tb/tb_snake_stream.sv
// tb/tb_snake_stream.sv - directed self-checking bench for snake_stream
module tb_snake_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, game_rst0, game_rst8;
  logic [4:0] hx0, hx8;
  logic [3:0] hy0, hy8;
  logic [5:0] len0, len8;
  logic       fail0, fail8, succ0, succ8;

  snake_stream_if b0();
  snake_stream_if b8();

  snake_stream u0 (
    .clk(clk), .rst(rst), .game_rst(game_rst0), .bus(b0),
    .snake_head_x(hx0), .snake_head_y(hy0), .length(len0), .failure(fail0), .success(succ0)
  );

  snake_stream #(.MAX_LEN(8)) u8 (
    .clk(clk), .rst(rst), .game_rst(game_rst8), .bus(b8),
    .snake_head_x(hx8), .snake_head_y(hy8), .length(len8), .failure(fail8), .success(succ8)
  );

  int         errors = 0;
  int         checks = 0;
  logic [4:0] gx [16];
  logic [3:0] gy [16];
  logic [1:0] gd [16];
  int         gn;
  bit         found, got;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int sel, input logic [1:0] d, input logic g);
    if (sel == 0) begin
      b0.move = 1'b1; b0.move_dir = d; b0.grow = g;
    end else begin
      b8.move = 1'b1; b8.move_dir = d; b8.grow = g;
    end
    tick();
    b0.move = 1'b0;
    b8.move = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      seen = (sel == 0) ? b0.move_done : b8.move_done;
    end
  endtask

  task automatic do_move(input int sel, input logic [1:0] d, input logic g, input string tag);
    bit seen;
    pulse(sel, d, g);
    wait_done(sel, 40, seen);
    check(tag, seen, 1);
  endtask

  task automatic grab();
    found = 1'b0;
    gn    = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (b0.snake_valid && b0.snake_first) found = 1'b1;
      else tick();
    end
    check("walk_found", found, 1);
    while (found && gn < 16) begin
      gx[gn] = b0.snake_x;
      gy[gn] = b0.snake_y;
      gd[gn] = b0.snake_dir;
      gn++;
      if (b0.snake_last || !b0.snake_valid) break;
      tick();
    end
  endtask

  task automatic chk_seg(input string tag, input int i, input logic [4:0] x, input logic [3:0] y);
    check(tag, {gx[i], gy[i]}, {x, y});
  endtask

  initial begin
    rst = 1'b1; game_rst0 = 1'b0; game_rst8 = 1'b0;
    b0.move = 1'b0; b0.move_dir = 2'd0; b0.grow = 1'b0;
    b8.move = 1'b0; b8.move_dir = 2'd0; b8.grow = 1'b0;
    tick();
    tick();
    check("rst_valid", b0.snake_valid, 0);
    check("rst_len", len0, 3);
    check("rst_head", {hx0, hy0}, {5'd4, 4'd7});
    check("rst_flags", {fail0, succ0, b0.move_done}, 0);
    check("rst_stream", {b0.snake_x, b0.snake_y, b0.snake_first}, 0);
    rst = 1'b0;

    grab();
    check("w0_n", gn, 3);
    chk_seg("w0_s0", 0, 5'd4, 4'd7);
    chk_seg("w0_s1", 1, 5'd3, 4'd7);
    chk_seg("w0_s2", 2, 5'd2, 4'd7);
    check("w0_dirs", {gd[0], gd[1], gd[2]}, 6'b101010);
    tick();
    check("w0_gap", b0.snake_valid, 0);
    tick();
    check("w0_period", {b0.snake_valid, b0.snake_first}, 2'b11);

    do_move(0, 2'd3, 1'b0, "mv_r_done");
    check("mv_r_gap", b0.snake_valid, 0);
    check("mv_r_head", {hx0, hy0}, {5'd5, 4'd7});
    check("mv_r_len", len0, 3);
    grab();
    check("w1_n", gn, 3);
    chk_seg("w1_s0", 0, 5'd5, 4'd7);
    chk_seg("w1_s1", 1, 5'd4, 4'd7);
    chk_seg("w1_s2", 2, 5'd3, 4'd7);

    do_move(0, 2'd3, 1'b1, "gr_done");
    check("gr_len", len0, 4);
    grab();
    check("w2_n", gn, 4);
    chk_seg("w2_s0", 0, 5'd6, 4'd7);
    chk_seg("w2_s3", 3, 5'd3, 4'd7);
    check("w2_dir0", gd[0], 2);

    // Second request while pending replaces the first one.
    tick();
    check("w2_gap", b0.snake_valid, 0);
    pulse(0, 2'd1, 1'b0);
    pulse(0, 2'd0, 1'b0);
    wait_done(0, 40, got);
    check("ovr_done", got, 1);
    check("ovr_head", {hx0, hy0}, {5'd6, 4'd6});
    grab();
    check("w3_n", gn, 4);
    chk_seg("w3_s0", 0, 5'd6, 4'd6);
    chk_seg("w3_s1", 1, 5'd6, 4'd7);
    chk_seg("w3_s3", 3, 5'd4, 4'd7);
    check("w3_dirs", {gd[0], gd[1]}, 4'b0110);

    for (int i = 0; i < 12; i++) do_move(0, 2'd3, 1'b0, "run_r_done");
    check("edge_head", {hx0, hy0}, {5'd18, 4'd6});
    check("edge_fail", fail0, 0);
    do_move(0, 2'd3, 1'b0, "wall_done");
`ifdef SNAKE_WRAP_EN
    check("wall_head", {hx0, hy0}, {5'd1, 4'd6});
    check("wall_fail", fail0, 0);
`else
    check("wall_head", {hx0, hy0}, {5'd18, 4'd6});
    check("wall_fail", fail0, 1);
`endif

    game_rst0 = 1'b1;
    tick();
    game_rst0 = 1'b0;
    check("grst_len", len0, 3);
    check("grst_head", {hx0, hy0}, {5'd4, 4'd7});
    check("grst_flags", {fail0, succ0}, 0);
    do_move(0, 2'd2, 1'b0, "neck_done");
    check("neck_fail", fail0, 1);
    check("neck_head", {hx0, hy0}, {5'd4, 4'd7});
    grab();
    check("w4_n", gn, 3);
    chk_seg("w4_s1", 1, 5'd3, 4'd7);
    chk_seg("w4_s2", 2, 5'd2, 4'd7);
    pulse(0, 2'd3, 1'b0);
    wait_done(0, 30, got);
    check("neck_ignored", got, 0);

    for (int i = 0; i < 5; i++) do_move(1, 2'd3, 1'b1, "g8_done");
    check("g8_len", len8, 8);
    check("g8_succ", succ8, 1);
    check("g8_fail", fail8, 0);
    check("g8_head", {hx8, hy8}, {5'd9, 4'd7});
    pulse(1, 2'd3, 1'b0);
    wait_done(1, 30, got);
    check("g8_ignored", got, 0);
    check("g8_len_hold", len8, 8);
    game_rst8 = 1'b1;
    tick();
    game_rst8 = 1'b0;
    check("g8_rst_len", len8, 3);
    check("g8_rst_flags", {fail8, succ8}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
